// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_pkg
// Purpose  : Shared constants, state encoding and helpers for the pattern
//            sequencer (pattern indices, speed limit, RUN/BLANK states).
// Revision : 1.0 - initial release
// ============================================================================
package pattern_pkg;

    // Generator indices as wired on the pattern_enable bus
    localparam logic [1:0] PAT_CHECKER  = 2'd0;
    localparam logic [1:0] PAT_STRIPES  = 2'd1;
    localparam logic [1:0] PAT_GRADIENT = 2'd2;
    localparam logic [1:0] PAT_PLASMA   = 2'd3;

    // Largest step_size the generators accept
    localparam logic [2:0] STEP_MAX = 3'd7;

    // Sequencer states: showing a pattern, or inserting black frames
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    // One-hot enable word for a generator index
    function automatic logic [3:0] onehot_sel(input logic [1:0] idx);
        onehot_sel = 4'b0001 << idx;
    endfunction

endpackage : pattern_pkg
`default_nettype wire

// File: rtl/frame_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : frame_edge_detect
// Purpose  : Frame-rate button edge detector. The button is sampled only on
//            next_frame, so a press must span a frame pulse to be seen and a
//            held button yields a single pulse.
// Revision : 1.0 - initial release
// ============================================================================
module frame_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic next_frame_i,
    input  logic btn_i,
    output logic press_o
);

    logic btn_prev_q;
    logic btn_prev_d;

    // History only moves on frame pulses; between frames it holds.
    always_comb begin
        btn_prev_d = btn_prev_q;
        if (next_frame_i) begin
            btn_prev_d = btn_i;
        end
    end

    // Button history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_prev_d;
        end
    end

    // Rising edge relative to the previous frame's sample, valid in the frame cycle only
    assign press_o = next_frame_i & btn_i & ~btn_prev_q;

endmodule : frame_edge_detect
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_sequencer
// Purpose  : Frame-rate controller selecting the active pattern generator and
//            its step_size. Advances on btn_next or an auto-cycle timeout,
//            inserting BLANK_FRAMES black frames at each switch.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int         NUM_PATTERNS = 4,
    parameter int         AUTO_FRAMES  = 240,
    parameter int         BLANK_FRAMES = 2,
    parameter logic [2:0] STEP_RESET   = 3'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       next_frame,
    input  logic       btn_next,
    input  logic       btn_faster,
    input  logic       btn_slower,
    input  logic       auto_mode,
    output logic [1:0] pattern_sel,
    output logic [3:0] pattern_enable,
    output logic [2:0] step_size,
    output logic       blank
);

    localparam int AUTO_W  = $clog2(AUTO_FRAMES);
    localparam int BLANK_W = $clog2(BLANK_FRAMES + 1);

    localparam logic [AUTO_W-1:0]  AUTO_LAST  = AUTO_W'(AUTO_FRAMES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_FRAMES - 1);
    localparam logic [1:0]         SEL_LAST   = 2'(NUM_PATTERNS - 1);

    state_e             state_q,     state_d;
    logic [1:0]         sel_q,       sel_d;
    logic [3:0]         enable_q,    enable_d;
    logic [2:0]         step_q,      step_d;
    logic               blank_q,     blank_d;
    logic [AUTO_W-1:0]  auto_cnt_q,  auto_cnt_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;

    logic press_next;
    logic press_faster;
    logic press_slower;
    logic auto_timeout;

    frame_edge_detect u_edge_next (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_frame_i (next_frame),
        .btn_i        (btn_next),
        .press_o      (press_next)
    );

    frame_edge_detect u_edge_faster (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_frame_i (next_frame),
        .btn_i        (btn_faster),
        .press_o      (press_faster)
    );

    frame_edge_detect u_edge_slower (
        .clk          (clk),
        .rst_n        (rst_n),
        .next_frame_i (next_frame),
        .btn_i        (btn_slower),
        .press_o      (press_slower)
    );

    // Timer expiry only counts while showing a pattern with auto-cycling on
    assign auto_timeout = (state_q == ST_RUN) && auto_mode && (auto_cnt_q == AUTO_LAST);

    // Next-state and output logic; everything holds unless a frame pulse arrives
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        step_d      = step_q;
        blank_d     = blank_q;
        auto_cnt_d  = auto_cnt_q;
        blank_cnt_d = blank_cnt_q;

        if (next_frame) begin
            // Simultaneous faster/slower presses cancel out
            if (press_faster && !press_slower) begin
                if (step_q != STEP_MAX) begin
                    step_d = step_q + 3'd1;
                end
            end else if (press_slower && !press_faster) begin
                if (step_q != 3'd0) begin
                    step_d = step_q - 3'd1;
                end
            end

            case (state_q)
                ST_RUN: begin
                    if (press_next || auto_timeout) begin
                        state_d     = ST_BLANK;
                        sel_d       = (sel_q == SEL_LAST) ? PAT_CHECKER : (sel_q + 2'd1);
                        enable_d    = 4'b0000;
                        blank_d     = 1'b1;
                        blank_cnt_d = BLANK_LOAD;
                        auto_cnt_d  = '0;
                    end else if (auto_mode) begin
                        auto_cnt_d = auto_cnt_q + AUTO_W'(1);
                    end else begin
                        auto_cnt_d = '0;
                    end
                end
                ST_BLANK: begin
                    // next presses here are dropped; their history still updates
                    auto_cnt_d = '0;
                    if (blank_cnt_q == '0) begin
                        state_d  = ST_RUN;
                        enable_d = onehot_sel(sel_q);
                        blank_d  = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            sel_q       <= PAT_CHECKER;
            enable_q    <= onehot_sel(PAT_CHECKER);
            step_q      <= STEP_RESET;
            blank_q     <= 1'b0;
            auto_cnt_q  <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            step_q      <= step_d;
            blank_q     <= blank_d;
            auto_cnt_q  <= auto_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign pattern_sel    = sel_q;
    assign pattern_enable = enable_q;
    assign step_size      = step_q;
    assign blank          = blank_q;

endmodule : pattern_sequencer
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_sequencer
// Purpose  : Self-checking bench for pattern_sequencer: directed scenarios
//            plus randomized frames against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

    localparam int NP = 4;
    localparam int AF = 4;
    localparam int BF = 2;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       next_frame = 1'b0;
    logic       btn_next   = 1'b0;
    logic       btn_faster = 1'b0;
    logic       btn_slower = 1'b0;
    logic       auto_mode  = 1'b0;
    logic [1:0] pattern_sel;
    logic [3:0] pattern_enable;
    logic [2:0] step_size;
    logic       blank;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept in frame terms
    int m_sel;
    int m_step;
    int m_blank_left;   // frame pulses still to pass before output returns
    int m_age;          // consecutive auto-mode frames spent showing the pattern
    bit m_pn, m_pf, m_ps;

    pattern_sequencer #(
        .NUM_PATTERNS (NP),
        .AUTO_FRAMES  (AF),
        .BLANK_FRAMES (BF),
        .STEP_RESET   (3'd2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_frame     (next_frame),
        .btn_next       (btn_next),
        .btn_faster     (btn_faster),
        .btn_slower     (btn_slower),
        .auto_mode      (auto_mode),
        .pattern_sel    (pattern_sel),
        .pattern_enable (pattern_enable),
        .step_size      (step_size),
        .blank          (blank)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_step = 2; m_blank_left = 0; m_age = 0;
        m_pn = 0; m_pf = 0; m_ps = 0;
    endtask

    task automatic model_step(input bit bn, input bit bf, input bit bs, input bit am);
        bit en_n, en_f, en_s, timeout;
        en_n = bn && !m_pn;
        en_f = bf && !m_pf;
        en_s = bs && !m_ps;
        m_pn = bn; m_pf = bf; m_ps = bs;
        if (en_f && !en_s) m_step = (m_step < 7) ? m_step + 1 : 7;
        else if (en_s && !en_f) m_step = (m_step > 0) ? m_step - 1 : 0;
        if (m_blank_left > 0) begin
            m_blank_left--;
            m_age = 0;
        end else begin
            timeout = am && (m_age == AF - 1);
            if (en_n || timeout) begin
                m_sel = (m_sel + 1) % NP;
                m_blank_left = BF;
                m_age = 0;
            end else begin
                m_age = am ? m_age + 1 : 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        int exp_en;
        exp_en = (m_blank_left > 0) ? 0 : (1 << m_sel);
        check_eq({tag, ".sel"},   int'(pattern_sel),    m_sel);
        check_eq({tag, ".en"},    int'(pattern_enable), exp_en);
        check_eq({tag, ".step"},  int'(step_size),      m_step);
        check_eq({tag, ".blank"}, int'(blank),          (m_blank_left > 0) ? 1 : 0);
    endtask

    // One frame: buttons set up with the pulse, outputs checked after it
    task automatic do_frame(input bit bn, input bit bf, input bit bs, input bit am);
        @(negedge clk);
        btn_next = bn; btn_faster = bf; btn_slower = bs; auto_mode = am;
        next_frame = 1'b1;
        model_step(bn, bf, bs, am);
        @(negedge clk);
        next_frame = 1'b0;
        check_model("frame");
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic press_next();
        do_frame(1, 0, 0, 0);
        do_frame(0, 0, 0, 0);
        do_frame(0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset.sel",   int'(pattern_sel),    0);
        check_eq("reset.en",    int'(pattern_enable), 1);
        check_eq("reset.step",  int'(step_size),      2);
        check_eq("reset.blank", int'(blank),          0);

        // single press enters blanking on the next pattern
        do_frame(1, 0, 0, 0);
        check_eq("adv.blank", int'(blank),          1);
        check_eq("adv.en",    int'(pattern_enable), 0);
        check_eq("adv.sel",   int'(pattern_sel),    1);
        do_frame(0, 0, 0, 0);
        check_eq("adv.midblank", int'(blank), 1);
        do_frame(0, 0, 0, 0);
        check_eq("adv.en2",    int'(pattern_enable), 2);
        check_eq("adv.blank2", int'(blank),          0);

        // held button advances once
        repeat (5) do_frame(1, 0, 0, 0);
        do_frame(0, 0, 0, 0);
        check_eq("hold.sel", int'(pattern_sel),    2);
        check_eq("hold.en",  int'(pattern_enable), 4);

        // wrap around back to pattern 0
        repeat (2) press_next();
        check_eq("wrap.sel0", int'(pattern_sel), 0);
        repeat (4) press_next();
        check_eq("wrap.sel", int'(pattern_sel),    0);
        check_eq("wrap.en",  int'(pattern_enable), 1);

        // speed saturation
        repeat (8) begin do_frame(0, 1, 0, 0); do_frame(0, 0, 0, 0); end
        check_eq("speed.max", int'(step_size), 7);
        repeat (9) begin do_frame(0, 0, 1, 0); do_frame(0, 0, 0, 0); end
        check_eq("speed.min", int'(step_size), 0);
        do_frame(0, 1, 0, 0); do_frame(0, 0, 0, 0);
        do_frame(0, 1, 1, 0);
        check_eq("speed.both", int'(step_size), 1);
        do_frame(0, 0, 0, 0);

        // auto advance on the 4th frame
        repeat (3) do_frame(0, 0, 0, 1);
        check_eq("auto.pre", int'(blank), 0);
        do_frame(0, 0, 0, 1);
        check_eq("auto.blank", int'(blank),       1);
        check_eq("auto.sel",   int'(pattern_sel), 1);
        repeat (2) do_frame(0, 0, 0, 1);

        // next press coinciding with timeout advances by one
        repeat (3) do_frame(0, 0, 0, 1);
        do_frame(1, 0, 0, 1);
        check_eq("coinc.sel", int'(pattern_sel), 2);
        do_frame(0, 0, 0, 1);
        do_frame(0, 0, 0, 1);
        check_eq("coinc.run", int'(blank), 0);

        // auto dropped at count 2
        repeat (2) do_frame(0, 0, 0, 1);
        repeat (10) do_frame(0, 0, 0, 0);
        check_eq("drop.sel",   int'(pattern_sel), 2);
        check_eq("drop.blank", int'(blank),       0);

        // reset in the middle of blanking
        do_frame(1, 0, 0, 0);
        do_frame(0, 0, 0, 0);
        check_eq("rstblank.in", int'(blank), 1);
        @(negedge clk);
        btn_next = 1'b1;
        #2;
        btn_next = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rstblank.sel",   int'(pattern_sel),    0);
        check_eq("rstblank.en",    int'(pattern_enable), 1);
        check_eq("rstblank.step",  int'(step_size),      2);
        check_eq("rstblank.blank", int'(blank),          0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) do_frame(0, 0, 0, 0);
        check_eq("rstblank.after", int'(pattern_sel), 0);

        // randomized frames against the model
        begin
            bit am;
            am = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 19) == 0) am = ~am;
                do_frame($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                         $urandom_range(0, 2) == 0, am);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pattern_sequencer
`default_nettype wire
